// File: rtl/sprite_fetch_scheduler_pkg.sv
// Shared types and constants for the sprite fetch scheduler: entity indices,
// ROM row bases, row type, FSM states and small row helpers.
package pacman_pkg;

    localparam int NUM_ENT = 5;
    localparam int ROM_LAT = 1;

    localparam logic [7:0] PLAYER_BASE = 8'd96;
    localparam logic [7:0] GHOST_BASE  = 8'd224;

    typedef logic [31:0] sprite_row_t;

    typedef enum logic [2:0] {
        ENT_PLAYER,
        ENT_RED,
        ENT_ORANGE,
        ENT_BLUE,
        ENT_PINK
    } ent_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } fetch_state_e;

    // Player rows are grouped per facing direction, 32 rows each.
    function automatic logic [7:0] row_base(input logic [2:0] idx, input logic [1:0] dir);
        return (idx == 3'(ENT_PLAYER)) ? PLAYER_BASE + {1'b0, dir, 5'd0} : GHOST_BASE;
    endfunction

    function automatic sprite_row_t mirror_row(input sprite_row_t row);
        sprite_row_t r;
        for (int i = 0; i < 32; i++) begin
            r[i] = row[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/sprite_fetch_scheduler_if.sv
// Shared sprite ROM port: the scheduler drives address/strobe, the ROM returns
// the row one cycle after the strobe.
interface sprite_fetch_scheduler_if;

    logic [7:0]                rom_addr;
    logic                      rom_rd;
    pacman_pkg::sprite_row_t   rom_data;

    modport master (output rom_addr, output rom_rd, input rom_data);
    modport slave  (input rom_addr, input rom_rd, output rom_data);

endinterface

// File: rtl/sprite_fetch_scheduler_row_buffer.sv
// Double-buffered per-entity row store: the shadow bank fills during blanking,
// the swap strobe publishes it (including a write landing on the same edge).
module sprite_row_buffer
    import pacman_pkg::*;
(
    input  logic                        Clk,
    input  logic                        Reset_n,
    input  logic                        i_clr,
    input  logic                        i_wr_en,
    input  logic [2:0]                  i_wr_idx,
    input  sprite_row_t                 i_wr_data,
    input  logic                        i_swap,
    output logic [NUM_ENT-1:0][31:0]    o_row_bits,
    output logic [NUM_ENT-1:0]          o_row_valid
);

    sprite_row_t [NUM_ENT-1:0] r_shadow;
    logic        [NUM_ENT-1:0] r_shadow_vld;
    sprite_row_t [NUM_ENT-1:0] r_active;
    logic        [NUM_ENT-1:0] r_active_vld;

    // NOTE: both banks are reset explicitly so nothing stale is ever published;
    // a store this small costs nothing to clear, unlike a RAM macro.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_shadow     <= '0;
            r_shadow_vld <= '0;
            r_active     <= '0;
            r_active_vld <= '0;
        end else if (i_swap) begin
            for (int i = 0; i < NUM_ENT; i++) begin
                if (i_wr_en && i_wr_idx == 3'(i)) begin
                    r_active[i]     <= i_wr_data;
                    r_active_vld[i] <= 1'b1;
                end else begin
                    r_active[i]     <= r_shadow[i];
                    r_active_vld[i] <= r_shadow_vld[i];
                end
            end
            r_shadow     <= '0;
            r_shadow_vld <= '0;
        end else if (i_clr) begin
            r_shadow     <= '0;
            r_shadow_vld <= '0;
        end else if (i_wr_en) begin
            r_shadow[i_wr_idx]     <= i_wr_data;
            r_shadow_vld[i_wr_idx] <= 1'b1;
        end
    end

    assign o_row_bits  = r_active;
    assign o_row_valid = r_active_vld;

endmodule

// File: rtl/sprite_fetch_scheduler.sv
// Fetches next-line sprite rows for five entities from one shared ROM during
// blanking. Optional SPRITE_MIRROR_EN bit-reverses ghost rows on ghost_flip.
module sprite_fetch_scheduler
    import pacman_pkg::*;
#(
    parameter int H_FETCH = 640,
    parameter int H_SWAP  = 799,
    parameter int V_LAST  = 524
) (
    input  logic                        Clk,
    input  logic                        Reset_n,
    input  logic [9:0]                  DrawX,
    input  logic [9:0]                  DrawY,
    input  logic [NUM_ENT-1:0][9:0]     ent_y,
    input  logic [9:0]                  spriteSize,
    input  logic [1:0]                  dir,
    input  logic [3:0]                  ghost_flip,
    sprite_fetch_scheduler_if.master    rom_if,
    output logic [NUM_ENT-1:0][31:0]    row_bits,
    output logic [NUM_ENT-1:0]          row_valid,
    output logic                        busy,
    output logic                        overrun
);

    localparam logic [2:0] LAST_IDX = 3'(NUM_ENT - 1);

    fetch_state_e   r_state;
    logic [2:0]     r_idx;
    logic [9:0]     r_next_line;
    logic           r_tag_vld;
    logic [2:0]     r_tag_idx;
    logic           r_busy;
    logic           r_overrun;

    logic               w_fetch_start;
    logic               w_swap;
    logic               w_hit;
    logic               w_clr;
    logic signed [11:0] w_line;
    logic signed [11:0] w_lo;
    logic signed [11:0] w_hi;
    logic [7:0]         w_addr;
    sprite_row_t        w_cap_row;

    assign w_fetch_start = (DrawX == 10'(H_FETCH));
    assign w_swap        = (DrawX == 10'(H_SWAP));
    assign w_clr         = (r_state == IDLE) && w_fetch_start && !w_swap;

    // Signed, widened range so a sprite straddling line 0 does not wrap.
    assign w_line = signed'({2'b00, r_next_line});
    assign w_lo   = signed'({2'b00, ent_y[r_idx]}) - signed'({2'b00, spriteSize});
    assign w_hi   = signed'({2'b00, ent_y[r_idx]}) + signed'({2'b00, spriteSize});
    assign w_hit  = (r_state == ISSUE) && (w_line >= w_lo) && (w_line <= w_hi);
    assign w_addr = 8'(w_line - w_lo) + row_base(r_idx, dir);

    assign rom_if.rom_rd   = w_hit;
    assign rom_if.rom_addr = w_hit ? w_addr : 8'd0;

`ifdef SPRITE_MIRROR_EN
    assign w_cap_row = (r_tag_idx != 3'(ENT_PLAYER) && ghost_flip[2'(r_tag_idx - 3'd1)])
                     ? mirror_row(rom_if.rom_data) : rom_if.rom_data;
`else
    logic w_unused_flip;
    assign w_unused_flip = ^ghost_flip;
    assign w_cap_row     = rom_if.rom_data;
`endif

    // NOTE: all state here is updated with <= so every register samples the
    // pre-edge values of its neighbours regardless of statement order.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_next_line <= '0;
            r_tag_vld   <= 1'b0;
            r_tag_idx   <= '0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_tag_vld <= w_hit;
            r_tag_idx <= r_idx;
            if (w_swap) begin
                // Swap always wins; an unfinished fetch is abandoned.
                if (r_state == ISSUE || r_state == DRAIN || w_fetch_start) begin
                    r_overrun <= 1'b1;
                end
                r_state   <= IDLE;
                r_busy    <= 1'b0;
                r_tag_vld <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_fetch_start) begin
                            r_next_line <= (DrawY == 10'(V_LAST)) ? 10'd0 : DrawY + 10'd1;
                            r_idx       <= '0;
                            r_state     <= ISSUE;
                            r_busy      <= 1'b1;
                        end
                    end
                    ISSUE: begin
                        if (r_idx == LAST_IDX) begin
                            r_state <= DRAIN;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                    DRAIN: begin
                        // With a one-cycle ROM the last read lands on this edge.
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                    end
                    DONE: r_state <= DONE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    sprite_row_buffer u_row_buffer (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .i_clr       (w_clr),
        .i_wr_en     (r_tag_vld),
        .i_wr_idx    (r_tag_idx),
        .i_wr_data   (w_cap_row),
        .i_swap      (w_swap),
        .o_row_bits  (row_bits),
        .o_row_valid (row_valid)
    );

    assign busy    = r_busy;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_sprite_fetch_scheduler.sv
// Randomized bench for sprite_fetch_scheduler against a line-level model of
// hit/address/publish rules; DrawX is driven directly so swaps can be placed early.
module tb_sprite_fetch_scheduler;

`ifdef SPRITE_MIRROR_EN
    localparam bit MIRROR = 1'b1;
`else
    localparam bit MIRROR = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [9:0]      draw_x;
    logic [9:0]      draw_y;
    logic [4:0][9:0] ent_y;
    logic [9:0]      sprite_size;
    logic [1:0]      dir;
    logic [3:0]      ghost_flip;
    logic [4:0][31:0] row_bits;
    logic [4:0]      row_valid;
    logic            busy;
    logic            overrun;

    logic [31:0] rom_mem [256];
    int          obs_addr[$];
    int          busy_cnt;
    bit          mon_en;
    bit          exp_overrun;
    int          n_vec;
    int          n_err;

    always #5 clk = ~clk;

    sprite_fetch_scheduler_if rif ();

    sprite_fetch_scheduler dut (
        .Clk        (clk),
        .Reset_n    (rst_n),
        .DrawX      (draw_x),
        .DrawY      (draw_y),
        .ent_y      (ent_y),
        .spriteSize (sprite_size),
        .dir        (dir),
        .ghost_flip (ghost_flip),
        .rom_if     (rif),
        .row_bits   (row_bits),
        .row_valid  (row_valid),
        .busy       (busy),
        .overrun    (overrun)
    );

    // Behavioural ROM with one cycle of read latency.
    always @(posedge clk) begin
        if (rif.rom_rd) rif.rom_data <= rom_mem[rif.rom_addr];
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (rif.rom_rd) obs_addr.push_back(int'(rif.rom_addr));
            if (busy) busy_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rev32(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = x[31-i];
        return r;
    endfunction

    // One blanking interval: fetch starts at DrawX=640, the swap (DrawX=799)
    // is placed s cycles later. Entity e is read in cycle e+1, lands in e+2.
    task automatic run_line(input int drawy, input int s);
        int          nl;
        int          lo;
        int          hi;
        int          base;
        int          a;
        int          exp_addr[$];
        logic [4:0]  exp_valid;
        logic [31:0] exp_row[5];
        int          exp_busy;

        nl        = (drawy == 524) ? 0 : drawy + 1;
        exp_valid = '0;
        for (int e = 0; e < 5; e++) begin
            exp_row[e] = '0;
            lo = int'(ent_y[e]) - int'(sprite_size);
            hi = int'(ent_y[e]) + int'(sprite_size);
            if (nl >= lo && nl <= hi) begin
                base = (e == 0) ? 96 + 32 * int'(dir) : 224;
                a    = (nl - lo + base) & 255;
                if (e + 1 <= s) exp_addr.push_back(a);
                if (e + 2 <= s) begin
                    exp_valid[e] = 1'b1;
                    exp_row[e]   = (MIRROR && e > 0 && ghost_flip[e-1]) ? rev32(rom_mem[a]) : rom_mem[a];
                end
            end
        end
        exp_busy = (s < 6) ? s : 6;
        if (s <= 6) exp_overrun = 1'b1;

        obs_addr.delete();
        busy_cnt = 0;
        mon_en   = 1'b1;
        draw_y   = 10'(drawy);
        for (int x = 637; x <= 640; x++) begin
            draw_x = 10'(x);
            step();
        end
        for (int c = 1; c <= s; c++) begin
            draw_x = (c == s) ? 10'd799 : 10'(640 + c);
            step();
        end
        mon_en = 1'b0;

        check("n_reads", obs_addr.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++)
            check($sformatf("rd_addr%0d", i), obs_addr[i], exp_addr[i]);
        check("busy_cycles", busy_cnt, exp_busy);
        check("busy_after", {31'd0, busy}, 32'd0);
        check("overrun", {31'd0, overrun}, {31'd0, exp_overrun});
        check("row_valid", {27'd0, row_valid}, {27'd0, exp_valid});
        for (int e = 0; e < 5; e++)
            check($sformatf("row_bits%0d", e), row_bits[e], exp_row[e]);

        draw_x = 10'd0;
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nl;
        int y;
        int s;

        n_vec = 0; n_err = 0; mon_en = 1'b0; busy_cnt = 0; exp_overrun = 1'b0;
        for (int i = 0; i < 256; i++) rom_mem[i] = $urandom;
        rst_n = 1'b0; draw_x = '0; draw_y = '0; sprite_size = '0; dir = '0; ghost_flip = '0;
        for (int e = 0; e < 5; e++) ent_y[e] = 10'd400;
        step(); step();

        check("rst_row_valid", {27'd0, row_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_rom_rd", {31'd0, rif.rom_rd}, 32'd0);
        check("rst_rom_addr", {24'd0, rif.rom_addr}, 32'd0);
        for (int e = 0; e < 5; e++) check($sformatf("rst_row%0d", e), row_bits[e], 32'd0);
        rst_n = 1'b1;
        step();

        // Player only.
        ent_y[0] = 10'd100; sprite_size = 10'd15; dir = 2'd2;
        run_line(99, 10);
        check("player_addr", obs_addr[0], 175);

        // All five on one line.
        for (int e = 0; e < 5; e++) ent_y[e] = 10'd200;
        sprite_size = 10'd8;
        run_line(199, 10);

        // Nothing overlaps.
        for (int e = 0; e < 5; e++) ent_y[e] = 10'd400;
        run_line(50, 10);

        // Last line wraps to line 0.
        for (int e = 0; e < 5; e++) ent_y[e] = 10'd520;
        ent_y[1] = 10'd5; sprite_size = 10'd10;
        run_line(524, 10);
        check("wrap_addr", obs_addr[0], 229);

        // Swap arrives three cycles into the fetch.
        for (int e = 0; e < 5; e++) ent_y[e] = 10'd200;
        sprite_size = 10'd8;
        run_line(199, 3);
        check("ovr_valid", {27'd0, row_valid}, 32'h3);

        // Reset in the middle of a fetch.
        draw_y = 10'd199;
        draw_x = 10'd640; step();
        draw_x = 10'd641; step();
        draw_x = 10'd642; step();
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_rd", {31'd0, rif.rom_rd}, 32'd0);
        check("mid_rst_overrun", {31'd0, overrun}, 32'd0);
        check("mid_rst_valid", {27'd0, row_valid}, 32'd0);
        check("mid_rst_row0", row_bits[0], 32'd0);
        draw_x = 10'd0;
        step(); step();
        rst_n = 1'b1;
        exp_overrun = 1'b0;
        step();

        // Randomized lines, mostly completing, some cut short by an early swap.
        for (int n = 0; n < 40; n++) begin
            nl = int'($urandom_range(0, 524));
            sprite_size = 10'($urandom_range(0, 31));
            dir = 2'($urandom_range(0, 3));
            ghost_flip = 4'($urandom_range(0, 15));
            for (int e = 0; e < 5; e++) begin
                y = nl + int'($urandom_range(0, 80)) - 40;
                if ($urandom_range(0, 3) == 0) y = int'($urandom_range(0, 1023));
                if (y < 0) y = 0;
                if (y > 1023) y = 1023;
                ent_y[e] = 10'(y);
            end
            s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 10;
            run_line((nl == 0) ? 524 : nl - 1, s);
        end

        // Mirror request on the red ghost.
        for (int e = 0; e < 5; e++) ent_y[e] = 10'd900;
        ent_y[1] = 10'd300; sprite_size = 10'd4; ghost_flip = 4'b0001;
        rom_mem[228] = 32'h0000_0001;
        run_line(299, 10);
        check("mirror_red", row_bits[1], MIRROR ? 32'h8000_0000 : 32'h0000_0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
